// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the architectural register file.
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/reg_file_32x32_if.sv
// Register-file bus: write-back port, load scoreboard set and two operand read ports.
interface reg_file_32x32_if;
  import cpu_pkg::*;

  logic     wr_en;
  reg_idx_t wr_addr;
  word_t    wr_data;
  reg_idx_t rd_addr_a;
  word_t    rd_data_a;
  reg_idx_t rd_addr_b;
  word_t    rd_data_b;
  logic     pend_set;
  reg_idx_t pend_addr;
  logic     busy_a;
  logic     busy_b;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, pend_set, pend_addr,
    input  rd_data_a, rd_data_b, busy_a, busy_b
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, pend_set, pend_addr,
    output rd_data_a, rd_data_b, busy_a, busy_b
  );
endinterface

// File: rtl/reg_file_32x32_read_port.sv
// One combinational operand read port with zero-index forcing and busy lookup.
// Optional write-through bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_read_port
  import cpu_pkg::*;
(
  input  logic             rst_n,
  input  word_t            rf_i [NREGS],
  input  logic [NREGS-1:0] pend_i,
  input  reg_idx_t         addr_i,
  input  logic             wr_en_i,
  input  reg_idx_t         wr_addr_i,
  input  word_t            wr_data_i,
  output word_t            data_o,
  output logic             busy_o
);
  logic hit;

  // Writes during reset are discarded, so they must not leak through the bypass.
  assign hit = rst_n && wr_en_i && (wr_addr_i == addr_i) && (addr_i != REG_ZERO);

  always_comb begin
    data_o = '0;
    busy_o = 1'b0;
    if (rst_n && addr_i != REG_ZERO) begin
`ifdef REGFILE_BYPASS_EN
      data_o = hit ? wr_data_i : rf_i[addr_i];
      busy_o = hit ? 1'b0 : pend_i[addr_i];
`else
      data_o = rf_i[addr_i];
      busy_o = pend_i[addr_i];
`endif
    end
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = &{1'b0, hit, wr_data_i};
`endif
endmodule

// File: rtl/reg_file_32x32.sv
// 32x32 MIPS register file: r0 hardwired to zero, one write port, two read ports,
// pending-load scoreboard. Optional REGFILE_BYPASS_EN enables write-through reads.
module reg_file_32x32
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  reg_file_32x32_if.slave  bus
);
  word_t            regs_q [1:NREGS-1];
  word_t            regs_d [1:NREGS-1];
  logic [NREGS-1:1] pend_q;
  logic [NREGS-1:1] pend_d;
  word_t            rf     [NREGS];
  logic [NREGS-1:0] pend_vec;

  // A load issued in the same cycle as an older write-back to that register wins.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int i = 1; i < NREGS; i++) begin
      if (bus.wr_en && bus.wr_addr == reg_idx_t'(i)) begin
        regs_d[i] = bus.wr_data;
        pend_d[i] = 1'b0;
      end
      if (bus.pend_set && bus.pend_addr == reg_idx_t'(i)) begin
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    rf[0] = '0;
    for (int i = 1; i < NREGS; i++) rf[i] = regs_q[i];
  end

  assign pend_vec = {pend_q, 1'b0};

  regfile_read_port u_port_a (
    .rst_n     (rst_n),
    .rf_i      (rf),
    .pend_i    (pend_vec),
    .addr_i    (bus.rd_addr_a),
    .wr_en_i   (bus.wr_en),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .data_o    (bus.rd_data_a),
    .busy_o    (bus.busy_a)
  );

  regfile_read_port u_port_b (
    .rst_n     (rst_n),
    .rf_i      (rf),
    .pend_i    (pend_vec),
    .addr_i    (bus.rd_addr_b),
    .wr_en_i   (bus.wr_en),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .data_o    (bus.rd_data_b),
    .busy_o    (bus.busy_b)
  );
endmodule

// File: tb/tb_reg_file_32x32.sv
// Directed self-checking bench for reg_file_32x32 (both bypass and non-bypass builds).
module tb_reg_file_32x32;
  import cpu_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  reg_file_32x32_if bus();

  reg_file_32x32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.pend_set  = 1'b0;
    bus.pend_addr = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 32'hFFFF_FFFF;
    bus.pend_set = 1'b1; bus.pend_addr = 5'd4;
    tick(); tick();
    idle();
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < NREGS; i++) begin
      bus.rd_addr_a = reg_idx_t'(i);
      bus.rd_addr_b = reg_idx_t'(NREGS - 1 - i);
      #1;
      checks += 4;
      if (bus.rd_data_a !== 32'h0) begin errors++; $display("FAIL reset_rd_a[%0d] got=%h exp=0", i, bus.rd_data_a); end
      if (bus.rd_data_b !== 32'h0) begin errors++; $display("FAIL reset_rd_b[%0d] got=%h exp=0", i, bus.rd_data_b); end
      if (bus.busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a[%0d] got=%b exp=0", i, bus.busy_a); end
      if (bus.busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b[%0d] got=%b exp=0", i, bus.busy_b); end
    end
  endtask

  task automatic test_write_read();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEAD_BEEF;
    tick();
    idle();
    bus.rd_addr_a = 5'd5; bus.rd_addr_b = 5'd5;
    #1;
    checks += 2;
    if (bus.rd_data_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_r5_a got=%h exp=deadbeef", bus.rd_data_a); end
    if (bus.rd_data_b !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_r5_b got=%h exp=deadbeef", bus.rd_data_b); end
  endtask

  task automatic test_zero();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h1234_5678;
    bus.rd_addr_a = 5'd0; bus.rd_addr_b = 5'd0;
    #1;
    checks++;
    if (bus.rd_data_a !== 32'h0) begin errors++; $display("FAIL r0_no_bypass got=%h exp=0", bus.rd_data_a); end
    tick();
    idle();
    #1;
    checks += 2;
    if (bus.rd_data_a !== 32'h0) begin errors++; $display("FAIL r0_a got=%h exp=0", bus.rd_data_a); end
    if (bus.rd_data_b !== 32'h0) begin errors++; $display("FAIL r0_b got=%h exp=0", bus.rd_data_b); end
    bus.pend_set = 1'b1; bus.pend_addr = 5'd0;
    tick();
    idle();
    #1;
    checks++;
    if (bus.busy_a !== 1'b0) begin errors++; $display("FAIL r0_pend got=%b exp=0", bus.busy_a); end
  endtask

  task automatic test_same_cycle();
    bus.rd_addr_a = 5'd7; bus.rd_addr_b = 5'd7;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'hA5A5_A5A5;
    #1;
    checks += 2;
    if (bus.rd_data_a !== (BYP ? 32'hA5A5_A5A5 : 32'h0)) begin errors++; $display("FAIL r7_same_a got=%h exp=%h", bus.rd_data_a, BYP ? 32'hA5A5_A5A5 : 32'h0); end
    if (bus.rd_data_b !== bus.rd_data_a) begin errors++; $display("FAIL r7_same_b got=%h exp=%h", bus.rd_data_b, BYP ? 32'hA5A5_A5A5 : 32'h0); end
    tick();
    idle();
    #1;
    checks++;
    if (bus.rd_data_a !== 32'hA5A5_A5A5) begin errors++; $display("FAIL r7_next got=%h exp=a5a5a5a5", bus.rd_data_a); end
  endtask

  task automatic test_pending();
    bus.pend_set = 1'b1; bus.pend_addr = 5'd9;
    bus.rd_addr_b = 5'd9; bus.rd_addr_a = 5'd8;
    #1;
    checks++;
    if (bus.busy_b !== 1'b0) begin errors++; $display("FAIL pend_before got=%b exp=0", bus.busy_b); end
    tick();
    idle();
    #1;
    checks += 2;
    if (bus.busy_b !== 1'b1) begin errors++; $display("FAIL pend_set got=%b exp=1", bus.busy_b); end
    if (bus.busy_a !== 1'b0) begin errors++; $display("FAIL pend_other got=%b exp=0", bus.busy_a); end
    tick();
    checks++;
    if (bus.busy_b !== 1'b1) begin errors++; $display("FAIL pend_hold got=%b exp=1", bus.busy_b); end
    bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h0000_0099;
    #1;
    checks++;
    if (bus.busy_b !== !BYP) begin errors++; $display("FAIL pend_wr_cycle got=%b exp=%b", bus.busy_b, !BYP); end
    tick();
    idle();
    #1;
    checks += 2;
    if (bus.busy_b !== 1'b0) begin errors++; $display("FAIL pend_cleared got=%b exp=0", bus.busy_b); end
    if (bus.rd_data_b !== 32'h99) begin errors++; $display("FAIL r9_data got=%h exp=99", bus.rd_data_b); end
  endtask

  task automatic test_set_clear();
    bus.pend_set = 1'b1; bus.pend_addr = 5'd3;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h11;
    tick();
    idle();
    bus.rd_addr_a = 5'd3;
    #1;
    checks += 2;
    if (bus.rd_data_a !== 32'h11) begin errors++; $display("FAIL setclr_data got=%h exp=11", bus.rd_data_a); end
    if (bus.busy_a !== 1'b1) begin errors++; $display("FAIL setclr_busy got=%b exp=1", bus.busy_a); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      bus.wr_en = 1'b1; bus.wr_addr = reg_idx_t'(10 + i); bus.wr_data = 32'h100 * i + 32'h1;
      tick();
    end
    idle();
    for (int i = 1; i <= 4; i++) begin
      bus.rd_addr_a = reg_idx_t'(10 + i);
      bus.rd_addr_b = reg_idx_t'(15 - i);
      #1;
      checks += 2;
      if (bus.rd_data_a !== 32'h100 * i + 32'h1) begin errors++; $display("FAIL b2b_a[%0d] got=%h exp=%h", i, bus.rd_data_a, 32'h100 * i + 32'h1); end
      if (bus.rd_data_b !== 32'h100 * (5 - i) + 32'h1) begin errors++; $display("FAIL b2b_b[%0d] got=%h exp=%h", i, bus.rd_data_b, 32'h100 * (5 - i) + 32'h1); end
    end
  endtask

  task automatic test_reset_mid();
    bus.pend_set = 1'b1; bus.pend_addr = 5'd9;
    tick();
    idle();
    bus.rd_addr_a = 5'd5; bus.rd_addr_b = 5'd9;
    #1;
    checks += 2;
    if (bus.rd_data_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pre_rst_r5 got=%h exp=deadbeef", bus.rd_data_a); end
    if (bus.busy_b !== 1'b1) begin errors++; $display("FAIL pre_rst_busy got=%b exp=1", bus.busy_b); end
    bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hCAFE_F00D;
    #1 rst_n = 1'b0;
    #1;
    checks += 3;
    if (bus.rd_data_a !== 32'h0) begin errors++; $display("FAIL rst_r5 got=%h exp=0", bus.rd_data_a); end
    if (bus.rd_data_b !== 32'h0) begin errors++; $display("FAIL rst_r9 got=%h exp=0", bus.rd_data_b); end
    if (bus.busy_b !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy_b); end
    tick();
    idle();
    #2 rst_n = 1'b1;
    #1;
    checks += 3;
    if (bus.rd_data_a !== 32'h0) begin errors++; $display("FAIL post_rst_r5 got=%h exp=0", bus.rd_data_a); end
    if (bus.rd_data_b !== 32'h0) begin errors++; $display("FAIL post_rst_r9 got=%h exp=0", bus.rd_data_b); end
    if (bus.busy_b !== 1'b0) begin errors++; $display("FAIL post_rst_busy got=%b exp=0", bus.busy_b); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_write_read();
    test_zero();
    test_same_cycle();
    test_pending();
    test_set_clear();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
